// File: rtl/hazard_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : hazard_decoder                                                 |
// | Purpose : Decodes wind direction from the rolling pattern of a three-    |
// |           lamp hazard light bar. Consecutive pattern transitions are     |
// |           classified (calm / right-to-left / left-to-right) and a class  |
// |           is confirmed once LOCK_COUNT matching transitions in a row     |
// |           have been seen. Protocol violations pulse error.               |
// | Ports   : clk          - system clock, rising edge                       |
// |           reset        - asynchronous active-high reset                  |
// |           lights[2:0]  - lamp pattern, bit 2 = left, bit 0 = right       |
// |           lights_valid - sample strobe                                   |
// |           clear_err    - synchronous clear of err_count                  |
// |           mode[1:0]    - 00 calm, 01 R->L, 10 L->R, 11 unknown          |
// |           locked       - mode holds a confirmed decode                   |
// |           error        - one-cycle protocol violation pulse              |
// |           err_count    - saturating error pulse count                    |
// | Config  : `define HAZARD_DECODER_ERRCNT_EN enables err_count/clear_err;  |
// |           otherwise err_count is tied to zero.                           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module hazard_decoder #(
  parameter int LOCK_COUNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] lights,
  input  logic       lights_valid,
  input  logic       clear_err,
  output logic [1:0] mode,
  output logic       locked,
  output logic       error,
  output logic [7:0] err_count
);

  // Transition classes double as mode encodings; "none" equals "unknown".
  localparam logic [1:0] c_cls_calm = 2'b00;
  localparam logic [1:0] c_cls_rl   = 2'b01;
  localparam logic [1:0] c_cls_lr   = 2'b10;
  localparam logic [1:0] c_cls_none = 2'b11;
  localparam logic [3:0] c_lock     = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t     r_state;
  logic [2:0] r_prev;
  logic [1:0] r_cand;   // candidate class in ACQUIRE, locked class in LOCKED
  logic [3:0] r_count;

  logic       w_pat_legal;
  logic [1:0] w_cls;
  logic [3:0] w_run;
  logic       w_err_evt;

  function automatic logic [1:0] classify(input logic [2:0] p, input logic [2:0] c);
    logic [1:0] cls;
    cls = c_cls_none;
    case ({p, c})
      6'b101_010, 6'b010_101:              cls = c_cls_calm;
      6'b001_010, 6'b010_100, 6'b100_001:  cls = c_cls_rl;
      6'b100_010, 6'b010_001, 6'b001_100:  cls = c_cls_lr;
      default:                             cls = c_cls_none;
    endcase
    return cls;
  endfunction

  assign w_pat_legal = (lights == 3'b001) || (lights == 3'b010) ||
                       (lights == 3'b100) || (lights == 3'b101);
  assign w_cls       = classify(r_prev, lights);
  assign w_run       = (w_cls == r_cand) ? (r_count + 4'd1) : 4'd1;

  // Single error source shared by the FSM output and the counter. In LOCKED
  // an illegal transition (class none) also differs from the locked class.
  assign w_err_evt = lights_valid &&
                     (!w_pat_legal ||
                      ((r_state == ST_ACQUIRE) && (w_cls == c_cls_none)) ||
                      ((r_state == ST_LOCKED)  && (w_cls != r_cand)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_prev  <= 3'b000;
      r_cand  <= c_cls_none;
      r_count <= 4'd0;
      mode    <= c_cls_none;
      locked  <= 1'b0;
      error   <= 1'b0;
    end else begin
      error <= w_err_evt;
      if (lights_valid) begin
        if (!w_pat_legal) begin
          r_state <= ST_IDLE;
          r_cand  <= c_cls_none;
          r_count <= 4'd0;
          mode    <= c_cls_none;
          locked  <= 1'b0;
        end else begin
          r_prev <= lights;
          unique case (r_state)
            ST_IDLE: begin
              r_state <= ST_ACQUIRE;
              r_cand  <= c_cls_none;
              r_count <= 4'd0;
            end
            ST_ACQUIRE: begin
              if (w_cls == c_cls_none) begin
                r_cand  <= c_cls_none;
                r_count <= 4'd0;
              end else begin
                r_cand  <= w_cls;
                r_count <= w_run;
                if (w_run >= c_lock) begin
                  r_state <= ST_LOCKED;
                  mode    <= w_cls;
                  locked  <= 1'b1;
                end
              end
            end
            ST_LOCKED: begin
              // A matching transition holds everything; any other drops lock.
              if (w_cls != r_cand) begin
                r_state <= ST_ACQUIRE;
                r_cand  <= w_cls;
                r_count <= (w_cls == c_cls_none) ? 4'd0 : 4'd1;
                mode    <= c_cls_none;
                locked  <= 1'b0;
              end
            end
            default: begin
              r_state <= ST_IDLE;
              r_cand  <= c_cls_none;
              r_count <= 4'd0;
              mode    <= c_cls_none;
              locked  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

`ifdef HAZARD_DECODER_ERRCNT_EN
  // Clear wins over accumulation, but an error on the same edge still counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= 8'd0;
    end else if (clear_err) begin
      err_count <= w_err_evt ? 8'd1 : 8'd0;
    end else if (w_err_evt && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  logic w_unused_clear_err;
  assign w_unused_clear_err = clear_err;
  assign err_count          = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_hazard_decoder                                              |
// | Purpose : Directed scoreboard bench for hazard_decoder (LOCK_COUNT = 3). |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_hazard_decoder;

`ifdef HAZARD_DECODER_ERRCNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] lights;
  logic       lights_valid;
  logic       clear_err;
  logic [1:0] mode;
  logic       locked;
  logic       error;
  logic [7:0] err_count;

  typedef struct packed {
    logic [15:0] id;
    logic [1:0]  mode;
    logic        locked;
    logic        error;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   total   = 0;
  int   bad     = 0;
  int   m_cnt   = 0;
  int   step_id = 0;

  always #5 clk = ~clk;

  hazard_decoder #(.LOCK_COUNT(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .lights       (lights),
    .lights_valid (lights_valid),
    .clear_err    (clear_err),
    .mode         (mode),
    .locked       (locked),
    .error        (error),
    .err_count    (err_count)
  );

  // Issue one cycle of stimulus and queue the outputs expected after its edge.
  task automatic step(input logic [2:0] l, input logic v, input logic c,
                      input logic [1:0] em, input logic el, input logic ee);
    exp_t e;
    @(negedge clk);
    lights       = l;
    lights_valid = v;
    clear_err    = c;
    if (c)                       m_cnt = ee ? 1 : 0;
    else if (ee && m_cnt < 255)  m_cnt = m_cnt + 1;
    e.id     = 16'(step_id);
    e.mode   = em;
    e.locked = el;
    e.error  = ee;
    e.cnt    = CNT_ON ? 8'(m_cnt) : 8'd0;
    sb.push_back(e);
    step_id = step_id + 1;
  endtask

  task automatic check_now(input string name, input logic [1:0] em, input logic el,
                           input logic ee, input logic [7:0] ec);
    total = total + 1;
    if ({mode, locked, error, err_count} !== {em, el, ee, ec}) begin
      bad = bad + 1;
      $display("FAIL %s: got mode=%b locked=%b error=%b err_count=%0d, want mode=%b locked=%b error=%b err_count=%0d",
               name, mode, locked, error, err_count, em, el, ee, ec);
    end
  endtask

  // Monitor: compare the DUT outputs after every edge that has an expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total = total + 1;
        if ({mode, locked, error, err_count} !== {e.mode, e.locked, e.error, e.cnt}) begin
          bad = bad + 1;
          $display("FAIL step%0d: got mode=%b locked=%b error=%b err_count=%0d, want mode=%b locked=%b error=%b err_count=%0d",
                   e.id, mode, locked, error, err_count, e.mode, e.locked, e.error, e.cnt);
        end
      end
    end
  end

  initial begin
    reset        = 1'b1;
    lights       = 3'b000;
    lights_valid = 1'b0;
    clear_err    = 1'b0;
    #7;
    check_now("reset_state", 2'b11, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    // Calm lock on the 4th sample
    step(3'b101, 1, 0, 2'b11, 0, 0);
    step(3'b010, 1, 0, 2'b11, 0, 0);
    step(3'b101, 1, 0, 2'b11, 0, 0);
    step(3'b010, 1, 0, 2'b00, 1, 0);

    // Illegal pattern while locked, then relock calm
    step(3'b111, 1, 0, 2'b11, 0, 1);
    step(3'b101, 1, 0, 2'b11, 0, 0);
    step(3'b010, 1, 0, 2'b11, 0, 0);
    step(3'b101, 1, 0, 2'b11, 0, 0);
    step(3'b010, 1, 0, 2'b00, 1, 0);

    // Back to IDLE, lock RL, then switch to LR
    step(3'b000, 1, 0, 2'b11, 0, 1);
    step(3'b001, 1, 0, 2'b11, 0, 0);
    step(3'b010, 1, 0, 2'b11, 0, 0);
    step(3'b100, 1, 0, 2'b11, 0, 0);
    step(3'b001, 1, 0, 2'b01, 1, 0);
    step(3'b010, 1, 0, 2'b01, 1, 0);
    step(3'b001, 1, 0, 2'b11, 0, 1);
    step(3'b100, 1, 0, 2'b11, 0, 0);
    step(3'b010, 1, 0, 2'b10, 1, 0);

    // LR lock broken by an RL transition, relock RL
    step(3'b100, 1, 0, 2'b11, 0, 1);
    step(3'b001, 1, 0, 2'b11, 0, 0);
    step(3'b010, 1, 0, 2'b01, 1, 0);
    step(3'b100, 1, 0, 2'b01, 1, 0);
    step(3'b001, 1, 0, 2'b01, 1, 0);
    step(3'b010, 1, 0, 2'b01, 1, 0);

    // Stall with valid low: outputs hold; clear_err still applies
    step(3'b111, 0, 0, 2'b01, 1, 0);
    step(3'b000, 0, 0, 2'b01, 1, 0);
    step(3'b000, 0, 1, 2'b01, 1, 0);
    step(3'b110, 0, 0, 2'b01, 1, 0);
    step(3'b010, 0, 0, 2'b01, 1, 0);

    // Repeated 010 is an illegal transition
    step(3'b010, 1, 0, 2'b11, 0, 1);
    step(3'b101, 1, 0, 2'b11, 0, 0);
    step(3'b101, 1, 0, 2'b11, 0, 1);

    // Counter saturation, then clear together with an error
    for (int i = 0; i < 260; i++) step(3'b111, 1, 0, 2'b11, 0, 1);
    step(3'b111, 1, 1, 2'b11, 0, 1);
    step(3'b000, 0, 0, 2'b11, 0, 0);

    // Relock calm, then asynchronous reset between edges
    step(3'b101, 1, 0, 2'b11, 0, 0);
    step(3'b010, 1, 0, 2'b11, 0, 0);
    step(3'b101, 1, 0, 2'b11, 0, 0);
    step(3'b010, 1, 0, 2'b00, 1, 0);
    @(posedge clk);
    #3;
    lights_valid = 1'b0;
    reset        = 1'b1;
    #1;
    check_now("async_reset", 2'b11, 1'b0, 1'b0, 8'd0);
    @(posedge clk);
    #1;
    check_now("reset_held", 2'b11, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    m_cnt = 0;

    // First sample after reset is an IDLE capture, no error despite no history
    step(3'b010, 1, 0, 2'b11, 0, 0);
    step(3'b001, 1, 0, 2'b11, 0, 0);
    step(3'b100, 1, 0, 2'b11, 0, 0);
    step(3'b010, 1, 0, 2'b10, 1, 0);
    step(3'b000, 0, 0, 2'b10, 1, 0);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    total = total + 1;
    if (sb.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_decoder.md
HAZARD_DECODER -- requirements
Module: hazard_decoder

Interface
REQ-001 Parameter LOCK_COUNT, default 3: consecutive same-class transitions needed to lock; legal range 1..15.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 lights  input  3  observed hazard light pattern; bit 2 = left lamp, bit 0 = right lamp.
REQ-005 lights_valid  input  1  sample strobe; lights is sampled only on edges where this is 1.
REQ-006 clear_err  input  1  synchronous clear of err_count.
REQ-007 mode  output  2  decoded wind: 00 calm, 01 right-to-left, 10 left-to-right, 11 unknown.
REQ-008 locked  output  1  high while mode is a confirmed decode.
REQ-009 error  output  1  one-cycle pulse on a protocol violation.
REQ-010 err_count  output  8  saturating count of error pulses.

Function
REQ-011 Legal pattern values SHALL be 001, 010, 100, 101; all others are illegal patterns.
REQ-012 Transition prev->cur SHALL classify as: calm = 101->010, 010->101; RL = 001->010, 010->100, 100->001; LR = 100->010, 010->001, 001->100; any other pair, including a repeated pattern, is an illegal transition.
REQ-013 The FSM SHALL have states IDLE (no stored pattern), ACQUIRE (candidate class plus 4-bit run count), and LOCKED.
REQ-014 IDLE: a legal sampled pattern SHALL be stored as prev and the FSM SHALL go to ACQUIRE with no candidate and count 0.
REQ-015 ACQUIRE: a classified transition equal to the candidate SHALL increment count; a different class SHALL become the new candidate with count 1.
REQ-016 ACQUIRE: when count reaches LOCK_COUNT, the FSM SHALL go to LOCKED on that same edge, with mode = candidate and locked = 1.
REQ-017 LOCKED: a transition of the locked class SHALL hold state.
REQ-018 LOCKED: a legal transition of a different class SHALL pulse error and go to ACQUIRE with that class as candidate and count 1, mode 11, locked 0.
REQ-019 Illegal transition in ACQUIRE or LOCKED SHALL pulse error, then go to ACQUIRE with no candidate and count 0, mode 11, locked 0.
REQ-020 Illegal pattern in any state SHALL pulse error and go to IDLE, mode 11, locked 0.
REQ-021 Every sample with a legal pattern SHALL update prev to cur.
REQ-022 With lights_valid = 0, all state and outputs SHALL hold, except: error deasserts, and clear_err applies.
REQ-023 All outputs SHALL be registered and SHALL reflect a sample on the same rising edge that captures it.
REQ-024 While not LOCKED, mode SHALL be 11.
REQ-025 err_count SHALL increment by 1 per error pulse and saturate at 255.
REQ-026 If clear_err and an error occur on the same edge, err_count SHALL become 1.

Reset
REQ-027 On reset, the FSM SHALL immediately enter IDLE with mode = 11, locked = 0, error = 0, err_count = 0, run count = 0, and prev invalid, independent of clk.
REQ-028 Reset asserted mid-acquisition or while locked SHALL discard all history.
REQ-029 After reset release, the first valid sample SHALL be treated as the IDLE case.

Configuration
REQ-030 Macro HAZARD_DECODER_ERRCNT_EN SHALL control the error counter.
REQ-031 Macro defined: the err_count counter and clear_err behaviour per REQ-025/026 SHALL be present.
REQ-032 Macro undefined: err_count SHALL be tied to 0, clear_err SHALL be ignored, and the error pulse SHALL be unchanged.

Verification
REQ-033 Calm lock: reset, then valid samples 101,010,101,010 (LOCK_COUNT 3) -> mode=00, locked=1 on 4th sample edge, error never high.
REQ-034 RL then LR: lock RL with 001,010,100,001, then feed 010,001 -> error pulse on the 010->001 edge, mode=11, locked=0; after 100,010 (LR count 3) -> mode=10, locked=1.
REQ-035 Illegal: while locked calm, feed 111 -> error 1 cycle, state IDLE, mode=11; next samples 101,010,101,010 relock calm.
REQ-036 Repeat/stall: locked RL, feed 010 twice consecutively -> error on the second edge; lights_valid=0 for 5 cycles in between -> outputs hold.
REQ-037 Counter: 260 illegal samples -> err_count=255; clear_err together with an error -> err_count=1; repeat with macro undefined -> err_count stays 0.
REQ-038 Async reset: assert reset between edges while locked -> mode=11, locked=0, err_count=0 before the next clk edge.
